// File: rtl/apple1_display_port.sv
// Apple-1 display output register ($D012) with a valid/ready character handshake to the renderer.
// Define APPLE1_DISPLAY_THROTTLE_EN to hold busy for THROTTLE_TICKS cpu_clken ticks after each transfer.
module apple1_display_port #(
  parameter int unsigned THROTTLE_TICKS = 16667
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       cpu_clken,
  input  logic       cpu_cs,
  input  logic       cpu_we,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       term_valid,
  output logic [6:0] term_char,
  input  logic       term_ready
);

`ifdef APPLE1_DISPLAY_THROTTLE_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_HOLD
  } state_t;

  localparam logic [14:0] LP_RELOAD = 15'(THROTTLE_TICKS - 32'd1);

  logic [14:0] r_count;
`else
  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_t;

  // The tick count only matters when the throttle is built in.
  logic [31:0] w_unused_throttle_ticks;
  assign w_unused_throttle_ticks = THROTTLE_TICKS;
`endif

  state_t     r_state;
  logic [6:0] r_char;
  logic       r_busy;
  logic       r_valid;

  logic w_write;
  logic w_xfer;
  logic w_unused_din7;

  assign w_write       = cpu_clken & cpu_cs & cpu_we;
  assign w_xfer        = r_valid & term_ready;
  assign w_unused_din7 = cpu_din[7];

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_char  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
`ifdef APPLE1_DISPLAY_THROTTLE_EN
      r_count <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_write) begin
            r_char  <= cpu_din[6:0];
            r_state <= ST_PEND;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
          end
        end
        ST_PEND: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
`ifdef APPLE1_DISPLAY_THROTTLE_EN
            if (THROTTLE_TICKS == 32'd0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_HOLD;
              r_count <= LP_RELOAD;
            end
`else
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`endif
          end
        end
`ifdef APPLE1_DISPLAY_THROTTLE_EN
        ST_HOLD: begin
          // Counter holds THROTTLE_TICKS-1 on entry, so the final tick is the one seeing zero.
          if (cpu_clken) begin
            if (r_count == '0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_count <= r_count - 15'd1;
            end
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_dout   = {r_busy, r_char};
  assign term_valid = r_valid;
  assign term_char  = r_char;

endmodule

// File: tb/tb_apple1_display_port.sv
// Scoreboarded random/directed bench for apple1_display_port with a tick-counting reference model.
module tb_apple1_display_port;

`ifdef APPLE1_DISPLAY_THROTTLE_EN
  localparam int MODEL_TICKS = 4;
`else
  localparam int MODEL_TICKS = 0;
`endif

  logic       sys_clock;
  logic       reset;
  logic       cpu_clken;
  logic       cpu_cs;
  logic       cpu_we;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       term_valid;
  logic [6:0] term_char;
  logic       term_ready;

  apple1_display_port #(.THROTTLE_TICKS(4)) dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .cpu_clken  (cpu_clken),
    .cpu_cs     (cpu_cs),
    .cpu_we     (cpu_we),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .term_valid (term_valid),
    .term_char  (term_char),
    .term_ready (term_ready)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  int          total;
  int          bad;
  int          n_xfer;
  int unsigned phase;
  logic        last_tick;
  logic [6:0]  exp_q[$];

  // Reference model: busy while a character is offered or fewer than MODEL_TICKS ticks have passed since its transfer.
  logic [6:0]  m_char;
  logic        m_offered;
  logic        m_busy;
  int          m_since;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: compare current outputs, then advance on the inputs the next edge will see.
  initial begin
    m_char    = '0;
    m_offered = 1'b0;
    m_since   = MODEL_TICKS;
    forever begin
      @(negedge sys_clock);
      #2;
      if (reset) begin
        m_char    = '0;
        m_offered = 1'b0;
        m_since   = MODEL_TICKS;
        exp_q.delete();
      end
      m_busy = m_offered || (m_since < MODEL_TICKS);
      check("outputs", 32'({cpu_dout, term_valid, term_char}),
            32'({m_busy, m_char, m_offered, m_char}));
      if (!reset) begin
        if (cpu_clken && cpu_cs && cpu_we && !m_busy) begin
          m_char    = cpu_din[6:0];
          m_offered = 1'b1;
          exp_q.push_back(cpu_din[6:0]);
        end else if (m_offered && term_ready) begin
          m_offered = 1'b0;
          m_since   = 0;
        end else if (!m_offered && (m_since < MODEL_TICKS) && cpu_clken) begin
          m_since++;
        end
      end
    end
  end

  // Monitor: every handshake pops one expected character.
  initial begin
    logic [6:0] exp_c;
    forever begin
      @(negedge sys_clock);
      #3;
      if (!reset && term_valid && term_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer_unexpected: got char 0x%0h expected no transfer at %0t", term_char, $time);
        end else begin
          exp_c = exp_q.pop_front();
          check("xfer_char", 32'(term_char), 32'(exp_c));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic cs, input logic we, input logic [7:0] din, input logic rdy);
    @(negedge sys_clock);
    cpu_clken  = (phase == 6);
    last_tick  = cpu_clken;
    phase      = (phase + 1) % 7;
    cpu_cs     = cs;
    cpu_we     = we;
    cpu_din    = din;
    term_ready = rdy;
    @(posedge sys_clock);
    #1;
  endtask

  task automatic noise(input logic rdy);
    step(1'($urandom_range(0, 1)), 1'b0, 8'($urandom), rdy);
  endtask

  task automatic write_on_tick(input logic [7:0] din, input logic rdy);
    while (phase != 6) noise(rdy);
    step(1'b1, 1'b1, din, rdy);
  endtask

  task automatic idle_tick(input logic rdy);
    while (phase != 6) noise(rdy);
    noise(rdy);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cpu_dout[7] && n < 200) begin
      noise(1'b1);
      n++;
    end
    check("wait_idle_bound", 32'(n < 200), 32'd1);
  endtask

  initial begin
    int base;
    int ticks;
    int n;
    total = 0; bad = 0; n_xfer = 0; phase = 0; last_tick = 1'b0;
    reset = 1'b1; cpu_clken = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
    cpu_din = '0; term_ready = 1'b0;

    repeat (3) @(negedge sys_clock);
    #1;
    check("reset_dout", 32'(cpu_dout), 32'h00);
    check("reset_valid", 32'(term_valid), 32'd0);
    check("reset_char", 32'(term_char), 32'h00);
    @(negedge sys_clock);
    reset = 1'b0;
    repeat (3) noise(1'b0);

    // Long renderer stall, then throttle countdown.
    write_on_tick(8'hC1, 1'b0);
    repeat (20) noise(1'b0);
    check("stall_dout", 32'(cpu_dout), 32'hC1);
    check("stall_valid", 32'(term_valid), 32'd1);
    check("stall_char", 32'(term_char), 32'h41);
    noise(1'b1);
    check("valid_clear", 32'(term_valid), 32'd0);
    ticks = 0;
    n = 0;
    while (cpu_dout[7] && n < 200) begin
      noise(1'b1);
      if (last_tick) ticks++;
      n++;
    end
    check("busy_ticks", 32'(ticks), 32'(MODEL_TICKS));
    check("after_busy_dout", 32'(cpu_dout), 32'h41);

    // Write while busy is dropped.
    base = n_xfer;
    write_on_tick(8'h41, 1'b0);
    write_on_tick(8'h42, 1'b0);
    check("drop_dout", 32'(cpu_dout), 32'hC1);
    wait_idle();
    check("drop_xfer_count", 32'(n_xfer - base), 32'd1);
    check("drop_char_reg", 32'(cpu_dout), 32'h41);

`ifdef APPLE1_DISPLAY_THROTTLE_EN
    // Write on the expiring tick is rejected; the next tick accepts it.
    write_on_tick(8'h50, 1'b1);
    noise(1'b1);
    for (int i = 0; i < MODEL_TICKS - 1; i++) idle_tick(1'b1);
    check("expiry_still_busy", 32'(cpu_dout[7]), 32'd1);
    write_on_tick(8'hD1, 1'b1);
    check("expiry_reject", 32'(cpu_dout), 32'h50);
    write_on_tick(8'hD1, 1'b1);
    check("expiry_accept", 32'(cpu_dout), 32'hD1);
    wait_idle();
`else
    // Ready tied high: back-to-back ticks both transfer.
    base = n_xfer;
    write_on_tick(8'h31, 1'b1);
    noise(1'b1);
    check("b2b_not_busy", 32'(cpu_dout[7]), 32'd0);
    write_on_tick(8'h32, 1'b1);
    noise(1'b1);
    check("b2b_xfer_count", 32'(n_xfer - base), 32'd2);
    check("b2b_dout", 32'(cpu_dout), 32'h32);
`endif

    // Asynchronous reset while pending.
    write_on_tick(8'h35, 1'b0);
    repeat (3) noise(1'b0);
    @(negedge sys_clock);
    reset = 1'b1;
    #1;
    check("areset_valid", 32'(term_valid), 32'd0);
    check("areset_dout", 32'(cpu_dout), 32'h00);
    repeat (2) noise(1'b1);
    @(negedge sys_clock);
    reset = 1'b0;
    base = n_xfer;
    repeat (10) noise(1'b1);
    check("areset_no_xfer", 32'(n_xfer - base), 32'd0);
    check("areset_dout_after", 32'(cpu_dout), 32'h00);

    // Random traffic against the model.
    repeat (500) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    wait_idle();
    noise(1'b1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
